// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and default constants for the reset sequencing controller.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int DEF_NUM_DOMAINS = 3;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/rst_seq_timer.sv
// Hold counter: counts up to hold_q and parks there, so a full-scale hold never wraps.
module rst_seq_timer
  import rst_seq_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] hold_q,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] cnt;

  assign done = (cnt == hold_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases per-domain active-low resets in index order with a
// programmable spacing, and re-runs the walk for software-requested domains.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CNT_WIDTH-1:0]   HOLD_CYCLES,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] SW_RST_MASK,
  output logic [NUM_DOMAINS-1:0] DOM_RST_N,
  output logic                   SW_RST_ACK,
  output logic                   BUSY
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rst_ok;
  seq_state_t             state;
  seq_state_t             state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [CNT_WIDTH-1:0]   hold_q;
  logic [CNT_WIDTH-1:0]   hold_nxt;
  logic [CNT_WIDTH-1:0]   hold_eff;
  logic                   loaded;
  logic [NUM_DOMAINS-1:0] dom_nxt;
  logic                   ack_nxt;
  logic                   busy_nxt;
  logic                   accept;
  logic                   last;
  logic                   done;
  logic                   timer_clear;
  logic                   timer_en;

  // Deassertion synchronizer: clears asynchronously, fills with ones after RST rises.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_ok = sync[SYNC_STAGES-1];

  assign accept      = (state == RUN) && SW_RST_REQ && (|SW_RST_MASK);
  assign last        = (idx == LAST_IDX);
  // Until the first live cycle latches hold_q, compare against the input directly.
  assign hold_eff    = loaded ? hold_q : HOLD_CYCLES;
  assign timer_en    = rst_ok && (state == HOLD);
  assign timer_clear = rst_ok && ((state == REL) || accept);

  rst_seq_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clear (timer_clear),
    .enable(timer_en),
    .hold_q(hold_eff),
    .done  (done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= HOLD;
    end else if (rst_ok) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLD:    if (done) state_nxt = REL;
      REL:     state_nxt = last ? RUN : HOLD;
      RUN:     if (accept) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  always_comb begin
    dom_nxt  = DOM_RST_N;
    ack_nxt  = 1'b0;
    busy_nxt = BUSY;
    idx_nxt  = idx;
    hold_nxt = hold_eff;
    unique case (state)
      REL: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          if (idx == IDX_W'(i)) dom_nxt[i] = 1'b1;
        end
        if (last) begin
          busy_nxt = 1'b0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          dom_nxt  = DOM_RST_N & ~SW_RST_MASK;
          ack_nxt  = 1'b1;
          busy_nxt = 1'b1;
          idx_nxt  = '0;
          hold_nxt = HOLD_CYCLES;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DOM_RST_N  <= '0;
      SW_RST_ACK <= 1'b0;
      BUSY       <= 1'b1;
      idx        <= '0;
      hold_q     <= '0;
      loaded     <= 1'b0;
    end else if (rst_ok) begin
      DOM_RST_N  <= dom_nxt;
      SW_RST_ACK <= ack_nxt;
      BUSY       <= busy_nxt;
      idx        <= idx_nxt;
      hold_q     <= hold_nxt;
      loaded     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a release-time model checked every cycle, plus directed literal checks.
module tb_rst_seq_ctrl;

  localparam int N   = 3;
  localparam int CW  = 8;
  localparam int SS  = 2;
  localparam int BIG = 1 << 30;

  logic          CLK;
  logic          RST;
  logic [CW-1:0] HOLD_CYCLES;
  logic          SW_RST_REQ;
  logic [N-1:0]  SW_RST_MASK;
  logic [N-1:0]  DOM_RST_N;
  logic          SW_RST_ACK;
  logic          BUSY;

  int total = 0;
  int bad   = 0;

  // Model: edge count since RST rose, and per-domain [low_from, rel_edge) assertion windows.
  int cyc;
  int seq_end;
  int ack_edge;
  int low_from [N];
  int rel_edge [N];
  logic [N-1:0] exp_dom;

  rst_seq_ctrl #(
    .NUM_DOMAINS(N),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .HOLD_CYCLES(HOLD_CYCLES),
    .SW_RST_REQ (SW_RST_REQ),
    .SW_RST_MASK(SW_RST_MASK),
    .DOM_RST_N  (DOM_RST_N),
    .SW_RST_ACK (SW_RST_ACK),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cyc      = 0;
    seq_end  = BIG;
    ack_edge = -1;
    for (int i = 0; i < N; i++) begin
      low_from[i] = 0;
      rel_edge[i] = BIG;
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      model_clear();
    end else begin
      cyc = cyc + 1;
      if (cyc == SS + 1) begin
        for (int i = 0; i < N; i++) rel_edge[i] = SS + (i + 1) * (int'(HOLD_CYCLES) + 2);
        seq_end = rel_edge[N-1];
      end else if (cyc > seq_end && SW_RST_REQ && SW_RST_MASK != '0) begin
        ack_edge = cyc;
        for (int i = 0; i < N; i++) begin
          if (SW_RST_MASK[i]) begin
            low_from[i] = cyc;
            rel_edge[i] = cyc + (i + 1) * (int'(HOLD_CYCLES) + 2);
          end
        end
        seq_end = cyc + N * (int'(HOLD_CYCLES) + 2);
      end
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) exp_dom[i] = !(cyc >= low_from[i] && cyc < rel_edge[i]);
    check("model_dom", DOM_RST_N, exp_dom);
    check("model_ack", SW_RST_ACK, (cyc == ack_edge));
    check("model_busy", BUSY, (cyc < seq_end));
  end

  task automatic wait_edge(input int k);
    int g = 0;
    while (cyc < k && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    check("reach_edge", cyc, k);
  endtask

  task automatic request(input logic [N-1:0] mask);
    SW_RST_REQ  = 1'b1;
    SW_RST_MASK = mask;
  endtask

  task automatic drop_request();
    SW_RST_REQ  = 1'b0;
    SW_RST_MASK = '0;
  endtask

  initial begin
    model_clear();
    RST         = 1'b0;
    HOLD_CYCLES = 8'd3;
    SW_RST_REQ  = 1'b0;
    SW_RST_MASK = '0;
    repeat (3) @(negedge CLK);
    check("rst_dom", DOM_RST_N, 3'b000);
    check("rst_busy", BUSY, 1'b1);
    check("rst_ack", SW_RST_ACK, 1'b0);
    RST = 1'b1;

    // Power-on with H=3 and a request held during the sequence (ignored).
    wait_edge(4);  request(3'b111);
    wait_edge(6);  check("po_e6", DOM_RST_N, 3'b000);
    wait_edge(7);  check("po_e7", DOM_RST_N, 3'b001);
    wait_edge(11); check("po_e11", DOM_RST_N, 3'b001);
    wait_edge(12); check("po_e12", DOM_RST_N, 3'b011);
    check("po_noack", SW_RST_ACK, 1'b0);
    drop_request();
    wait_edge(16); check("po_busy16", BUSY, 1'b1);
    wait_edge(17); check("po_e17", DOM_RST_N, 3'b111);
    check("po_busy17", BUSY, 1'b0);

    // Software request, mask 110, accepted at edge 20.
    wait_edge(19); request(3'b110);
    wait_edge(20); check("sw_dom_e0", DOM_RST_N, 3'b001);
    check("sw_ack_e0", SW_RST_ACK, 1'b1);
    check("sw_busy_e0", BUSY, 1'b1);
    drop_request();
    wait_edge(21); check("sw_ack_e1", SW_RST_ACK, 1'b0);
    wait_edge(29); check("sw_e9", DOM_RST_N, 3'b001);
    wait_edge(30); check("sw_e10", DOM_RST_N, 3'b011);
    wait_edge(35); check("sw_e15", DOM_RST_N, 3'b111);
    check("sw_busy_e15", BUSY, 1'b0);

    // Empty mask in RUN is ignored.
    wait_edge(37); request(3'b000);
    wait_edge(41); check("mask0_ack", SW_RST_ACK, 1'b0);
    check("mask0_dom", DOM_RST_N, 3'b111);
    drop_request();

    // H=0: spacing of 2 cycles, accepted at edge 43.
    wait_edge(42); HOLD_CYCLES = 8'd0; request(3'b111);
    wait_edge(43); check("h0_ack", SW_RST_ACK, 1'b1);
    check("h0_dom43", DOM_RST_N, 3'b000);
    drop_request();
    wait_edge(44); check("h0_dom44", DOM_RST_N, 3'b000);
    wait_edge(45); check("h0_dom45", DOM_RST_N, 3'b001);
    wait_edge(47); check("h0_dom47", DOM_RST_N, 3'b011);
    wait_edge(49); check("h0_dom49", DOM_RST_N, 3'b111);

    // H=3 latched at edge 51; H changed to 10 mid-sequence; pending request waits for RUN.
    wait_edge(50); HOLD_CYCLES = 8'd3; request(3'b001);
    wait_edge(51); check("mid_ack", SW_RST_ACK, 1'b1);
    check("mid_dom51", DOM_RST_N, 3'b110);
    request(3'b100);
    wait_edge(53); HOLD_CYCLES = 8'd10;
    wait_edge(55); check("mid_dom55", DOM_RST_N, 3'b110);
    wait_edge(56); check("mid_dom56", DOM_RST_N, 3'b111);
    wait_edge(66); check("mid_busy66", BUSY, 1'b0);
    check("mid_noack66", SW_RST_ACK, 1'b0);
    wait_edge(67); check("pend_ack67", SW_RST_ACK, 1'b1);
    check("pend_dom67", DOM_RST_N, 3'b011);
    drop_request();
    wait_edge(102); check("pend_dom102", DOM_RST_N, 3'b011);
    wait_edge(103); check("pend_dom103", DOM_RST_N, 3'b111);

    // H=255: spacing of 257 cycles with no counter wrap, accepted at edge 106.
    wait_edge(105); HOLD_CYCLES = 8'd255; request(3'b111);
    wait_edge(106); check("h255_ack", SW_RST_ACK, 1'b1);
    drop_request();
    wait_edge(362); check("h255_dom362", DOM_RST_N, 3'b000);
    wait_edge(363); check("h255_dom363", DOM_RST_N, 3'b001);
    wait_edge(619); check("h255_dom619", DOM_RST_N, 3'b001);
    wait_edge(620); check("h255_dom620", DOM_RST_N, 3'b011);
    wait_edge(877); check("h255_dom877", DOM_RST_N, 3'b111);
    check("h255_busy", BUSY, 1'b0);

    // RST falls while ACK is high in a software sequence.
    wait_edge(880); HOLD_CYCLES = 8'd3; request(3'b011);
    wait_edge(881); check("ar_ack_pre", SW_RST_ACK, 1'b1);
    check("ar_dom_pre", DOM_RST_N, 3'b100);
    #1 RST = 1'b0;
    #1;
    check("ar_dom", DOM_RST_N, 3'b000);
    check("ar_busy", BUSY, 1'b1);
    check("ar_ack", SW_RST_ACK, 1'b0);
    drop_request();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    wait_edge(6);  check("ar_po_e6", DOM_RST_N, 3'b000);
    wait_edge(7);  check("ar_po_e7", DOM_RST_N, 3'b001);
    wait_edge(12); check("ar_po_e12", DOM_RST_N, 3'b011);
    wait_edge(17); check("ar_po_e17", DOM_RST_N, 3'b111);
    check("ar_po_busy", BUSY, 1'b0);

    // Sub-cycle RST pulse, then power-on with H=0.
    wait_edge(20); HOLD_CYCLES = 8'd0;
    #1 RST = 1'b0;
    #1;
    check("sp_dom", DOM_RST_N, 3'b000);
    check("sp_busy", BUSY, 1'b1);
    #1 RST = 1'b1;
    wait_edge(3); check("sp_e3", DOM_RST_N, 3'b000);
    wait_edge(4); check("sp_e4", DOM_RST_N, 3'b001);
    wait_edge(6); check("sp_e6", DOM_RST_N, 3'b011);
    wait_edge(8); check("sp_e8", DOM_RST_N, 3'b111);
    check("sp_busy8", BUSY, 1'b0);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencing controller in the always-on reference clock domain. It takes the board-level asynchronous reset and drives one active-low reset request per clock domain, releasing them in fixed index order with a programmable spacing. It also accepts software reset requests for a selected subset of domains. Each DOM_RST_N bit feeds that domain's own reset synchronizer, which lives outside this block.

## Interface
Parameters:
- NUM_DOMAINS, 3: number of domain reset outputs; must be ≥1.
- CNT_WIDTH, 8: width of the hold counter and of HOLD_CYCLES.
- SYNC_STAGES, 2: flops in the internal RST deassertion synchronizer; must be ≥2.

Ports:
- CLK  in  1  reference clock.
- RST  in  1  reset, asynchronous, active-low.
- HOLD_CYCLES  in  CNT_WIDTH  spacing control; latched at sequence start.
- SW_RST_REQ  in  1  software reset request, level-sampled in RUN only.
- SW_RST_MASK  in  NUM_DOMAINS  domains to reset on request; bit i maps to domain i.
- DOM_RST_N  out  NUM_DOMAINS  per-domain reset, active-low, registered.
- SW_RST_ACK  out  1  one-cycle pulse when a request is accepted.
- BUSY  out  1  high while any sequence is in progress.

## Operation
- The internal synchronizer is a SYNC_STAGES-deep flop chain fed with 1. It resets asynchronously to 0 on RST low. Its last stage is rst_ok.
- The FSM, hold counter cnt, domain index idx and latched hold value hold_q advance only while rst_ok=1.
- FSM states:
  - HOLD: if cnt != hold_q, then cnt++. If cnt == hold_q, go to REL.
  - REL (one cycle): set DOM_RST_N[idx]=1 and cnt=0.
    - If idx == NUM_DOMAINS-1: go to RUN and set BUSY=0.
    - Otherwise: idx++ and go to HOLD.
  - RUN: idle, BUSY=0. Request acceptance rules:
    - If SW_RST_REQ=1 and SW_RST_MASK != 0: DOM_RST_N &= ~SW_RST_MASK, SW_RST_ACK=1 for one cycle, idx=0, cnt=0, hold_q=HOLD_CYCLES, BUSY=1, go to HOLD.
    - If SW_RST_MASK == 0: the request is ignored and there is no ACK.
- REL always walks every index 0..NUM_DOMAINS-1. Setting a bit that is already 1 is harmless, so domains outside the mask stay released throughout. This keeps sequence length independent of the mask.
- Requests arriving in HOLD or REL are ignored with no ACK. The requester holds SW_RST_REQ until it sees ACK.
- hold_q is loaded with HOLD_CYCLES on the first rst_ok cycle and on request acceptance. Changing HOLD_CYCLES mid-sequence has no effect.
- Reset values while RST=0: DOM_RST_N=0 (all domains), SW_RST_ACK=0, BUSY=1, state=HOLD, idx=0, cnt=0, hold_q=0.

## Timing
Edges are counted from the first CLK rising edge after RST rises (edge 1).
- rst_ok goes high at edge SYNC_STAGES. hold_q is captured at edge SYNC_STAGES+1.
- Power-on release: domain i's DOM_RST_N rises at edge SYNC_STAGES + (i+1)·(HOLD_CYCLES+2).
- BUSY falls on the same edge as the last domain's release.
- Software sequence: let e0 be the edge at which the request is accepted.
  - The masked bits fall and SW_RST_ACK rises at e0.
  - Domain i is released at e0 + (i+1)·(HOLD_CYCLES+2).
  - Minimum assertion width for a masked domain is HOLD_CYCLES+2 cycles.
- HOLD_CYCLES=0 gives a spacing of 2 cycles.
- HOLD_CYCLES at its maximum (2^CNT_WIDTH−1) must not wrap cnt.
- RST falling at any point: all outputs return to their reset values immediately (asynchronously), and any sequence in progress is abandoned.
- RST pulse shorter than one CLK period: the synchronizer still clears, and a full power-on sequence follows.

## Structure
- The shared package holds the FSM state enum (HOLD, REL, RUN) and the default parameter constants.
- One natural sub-module: rst_seq_timer, the CNT_WIDTH hold counter. Interface: clear, enable, hold_q, done.
- Synchronizer, FSM, idx register and DOM_RST_N register stay in the top module.

## Test plan
- Power-on, NUM_DOMAINS=3, SYNC_STAGES=2, HOLD_CYCLES=3 → DOM_RST_N goes 000→001 at edge 7, 011 at edge 12, 111 at edge 17. BUSY falls at edge 17.
- In RUN, apply SW_RST_REQ=1 with SW_RST_MASK=3'b110 at edge e0 → DOM_RST_N=001 and a one-cycle ACK at e0. Bit 1 released at e0+10, bit 2 at e0+15. Bit 0 stays 1 throughout.
- SW_RST_REQ during power-on sequence, and SW_RST_MASK=0 in RUN → no ACK, DOM_RST_N unchanged.
- HOLD_CYCLES=0, then HOLD_CYCLES=255 with CNT_WIDTH=8 → releases spaced 2 and 257 cycles respectively. No counter wrap.
- RST pulled low mid software sequence → DOM_RST_N=000, BUSY=1, ACK=0 immediately. Full power-on timing repeats after RST rises.
- HOLD_CYCLES changed from 3 to 10 mid-sequence → spacing stays 5 until the next sequence start.
